// File: rtl/countdown_timer.sv
// countdown_timer: loadable, pausable down-counter with terminal-count detection.
// A load starts a run of N enabled cycles; at terminal count the timer either
// reloads N (periodic) or stops in DONE until acknowledged (one-shot).
//
// state | meaning
// IDLE  | stopped, count held, enable/ack ignored
// RUN   | counting down on enabled edges
// DONE  | one-shot completed, done held until ack
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             ack,
  output logic [WIDTH-1:0] count_out,
  output logic             running,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= ZERO;
      reload_q  <= ZERO;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  // Next-state and next-count: load wins, then terminal/decrement, then ack.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (load) begin
      // A load discards any terminal event in the same cycle, so no pulse.
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != ZERO) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count_q == ONE) begin
              expired_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = ZERO;
                state_d = DONE;
              end
            end else if (count_q != ZERO) begin
              // Guarded so the count can never wrap below zero.
              count_d = count_q - ONE;
            end
          end
        end
        DONE: begin
          if (ack) state_d = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state and registered count/pulse.
  always_comb begin
    count_out = count_q;
    expired   = expired_q;
    running   = (state_q == RUN);
    done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios followed by random
// stimulus, all compared against a behavioural timer model every cycle.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         auto_reload = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] count_out;
  logic         running;
  logic         expired;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining cycles, period, and flags.
  int m_remaining = 0;
  int m_period    = 0;
  bit m_counting  = 0;
  bit m_finished  = 0;
  bit m_pulse     = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .ack        (ack),
    .count_out  (count_out),
    .running    (running),
    .expired    (expired),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic model_edge(input bit rs, input bit en, input bit ld,
                            input int lv, input bit ar, input bit ak);
    m_pulse = 0;
    if (rs) begin
      m_remaining = 0; m_period = 0; m_counting = 0; m_finished = 0;
    end else if (ld) begin
      m_remaining = lv; m_period = lv; m_counting = (lv > 0); m_finished = 0;
    end else if (m_counting) begin
      if (en) begin
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin
          m_pulse = 1;
          if (ar) m_remaining = m_period;
          else begin
            m_counting = 0;
            m_finished = 1;
          end
        end
      end
    end else if (m_finished && ak) begin
      m_finished = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (count_out === W'(m_remaining)) else begin
      errors++;
      $error("FAIL %s count_out observed=%0d expected=%0d", tag, count_out, m_remaining);
    end
    checks++;
    assert (running === m_counting) else begin
      errors++;
      $error("FAIL %s running observed=%0b expected=%0b", tag, running, m_counting);
    end
    checks++;
    assert (expired === m_pulse) else begin
      errors++;
      $error("FAIL %s expired observed=%0b expected=%0b", tag, expired, m_pulse);
    end
    checks++;
    assert (done === m_finished) else begin
      errors++;
      $error("FAIL %s done observed=%0b expected=%0b", tag, done, m_finished);
    end
  endtask

  // One clock cycle: drive inputs, clock edge, update model, compare.
  task automatic step(input string tag, input bit rs, input bit en, input bit ld,
                      input int lv, input bit ar, input bit ak);
    @(negedge clock);
    reset = rs; enable = en; load = ld; load_value = W'(lv);
    auto_reload = ar; ack = ak;
    @(posedge clock);
    model_edge(rs, en, ld, lv, ar, ak);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bit pat[10];
    pat = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1};

    step("reset", 1, 0, 0, 0, 0, 0);
    step("reset_hold", 1, 1, 0, 5, 0, 1);

    // Reset in the middle of a run
    step("mid_load9", 0, 0, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) step("mid_en", 0, 1, 0, 0, 0, 0);
    checks++;
    assert (count_out === 4'd6) else begin
      errors++;
      $error("FAIL mid_count6 observed=%0d expected=6", count_out);
    end
    step("mid_reset", 1, 0, 0, 0, 0, 0);
    step("mid_en_after", 0, 1, 0, 0, 0, 0);

    // One-shot
    step("os_load5", 0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 5; i++) step("os_en", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("os_idle", 0, 0, 0, 0, 0, 0);
    step("os_ack", 0, 0, 0, 0, 0, 1);
    step("os_after_ack", 0, 1, 0, 0, 0, 0);

    // Periodic with enable gaps
    step("per_load3", 0, 0, 1, 3, 1, 0);
    for (int i = 0; i < 10; i++) step("per_gap", 0, pat[i], 0, 0, 1, 0);

    // Boundaries
    step("b_load15", 0, 0, 1, 15, 0, 0);
    for (int i = 0; i < 15; i++) step("b_en15", 0, 1, 0, 0, 0, 0);
    step("b_ack", 0, 0, 0, 0, 0, 1);
    step("b_load1", 0, 0, 1, 1, 0, 0);
    step("b_en1", 0, 1, 0, 0, 0, 0);
    step("b_load0", 0, 0, 1, 0, 0, 0);
    step("b_load0_en", 0, 1, 0, 0, 0, 0);

    // Load colliding with terminal, and load with ack in DONE
    step("sim_load2", 0, 0, 1, 2, 0, 0);
    step("sim_en", 0, 1, 0, 0, 0, 0);
    step("sim_load7_term", 0, 1, 1, 7, 0, 0);
    step("sim_after", 0, 0, 0, 0, 0, 0);
    step("sim_load1", 0, 0, 1, 1, 0, 0);
    step("sim_term", 0, 1, 0, 0, 0, 0);
    step("sim_load4_ack", 0, 0, 1, 4, 0, 1);

    // Hold and ignore
    step("hold_load9", 0, 0, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) step("hold_en", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("hold_off", 0, 0, 0, 0, 0, 0);
    step("hold_ack_run", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step("hold_finish", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("done_en", 0, 1, 0, 0, 0, 0);
    step("done_ack", 0, 0, 0, 0, 0, 1);

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      bit rs, en, ld, ar, ak;
      int lv;
      rs = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 11) == 0);
      lv = $urandom_range(0, (1 << W) - 1);
      ar = $urandom_range(0, 1);
      ak = ($urandom_range(0, 3) == 0);
      step("rand", rs, en, ld, lv, ar, ak);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
